// File: rtl/rr_arbiter_requester.sv
// Requester-side front end: four per-channel FIFOs feeding one registered bus, popped on one-hot GNT.
// Optional wasted-grant statistics counter enabled by defining RR_REQ_STATS_EN.
module rr_arbiter_requester #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          wr_en,
  input  logic [4*DATA_W-1:0] wr_data,
  output logic [3:0]          full,
  output logic [3:0]          REQ,
  input  logic [3:0]          GNT,
  output logic                bus_valid,
  output logic [1:0]          bus_id,
  output logic [DATA_W-1:0]   bus_data,
  output logic                gnt_err,
  output logic [7:0]          waste_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [4][DEPTH];
  logic [AW-1:0]     rd_ptr [4];
  logic [AW-1:0]     wr_ptr [4];
  logic [CW-1:0]     count [4];
  logic [CW-1:0]     count_next [4];
  logic [3:0]        push;
  logic [3:0]        pop;
  logic              gnt_ok;

  always_comb begin
    gnt_ok = (GNT != 4'd0) && ((GNT & (GNT - 4'd1)) == 4'd0);
    full   = '0;
    push   = '0;
    pop    = '0;
    for (int i = 0; i < 4; i++) begin
      full[i] = (count[i] == CW'(DEPTH));
      // a push into a full channel is dropped even if that channel pops this cycle
      push[i] = wr_en[i] & ~full[i];
      pop[i]  = gnt_ok & GNT[i] & (count[i] != '0);
      count_next[i] = count[i];
      if (push[i] && !pop[i])
        count_next[i] = count[i] + CW'(1);
      else if (pop[i] && !push[i])
        count_next[i] = count[i] - CW'(1);
    end
  end

  // storage is not reset; occupancy counts alone decide what is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= wr_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      REQ       <= '0;
      bus_valid <= 1'b0;
      bus_id    <= '0;
      bus_data  <= '0;
      gnt_err   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        count[i] <= count_next[i];
        REQ[i]   <= (count_next[i] != '0);
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
      end
      if (GNT != 4'd0 && !gnt_ok) gnt_err <= 1'b1;
      bus_valid <= |pop;
      for (int i = 0; i < 4; i++) begin
        if (pop[i]) begin
          bus_id   <= 2'(i);
          bus_data <= mem[i][rd_ptr[i]];
        end
      end
    end
  end

`ifdef RR_REQ_STATS_EN
  logic waste_hit;

  always_comb begin
    waste_hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (gnt_ok && GNT[i] && count[i] == '0) waste_hit = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      waste_cnt <= '0;
    else if (waste_hit && waste_cnt != 8'hFF)
      waste_cnt <= waste_cnt + 8'd1;
  end
`else
  assign waste_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_arbiter_requester.sv
// Scoreboard bench for rr_arbiter_requester: queue-based channel model, decoupled bus monitor.
module tb_rr_arbiter_requester;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    wr_en;
  logic [4*DW-1:0] wr_data;
  logic [3:0]    full;
  logic [3:0]    REQ;
  logic [3:0]    GNT;
  logic          bus_valid;
  logic [1:0]    bus_id;
  logic [DW-1:0] bus_data;
  logic          gnt_err;
  logic [7:0]    waste_cnt;

  rr_arbiter_requester #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .REQ(REQ), .GNT(GNT), .bus_valid(bus_valid), .bus_id(bus_id),
    .bus_data(bus_data), .gnt_err(gnt_err), .waste_cnt(waste_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mq [4][$];
  logic [DW+1:0] exp_q [$];
  logic          m_err;
  int            m_waste;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every bus word must match the oldest expected pop.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_valid) begin
        if (exp_q.size() == 0) begin
          chk("bus_spurious", 32'(bus_valid), 32'd0);
        end else begin
          logic [DW+1:0] e;
          e = exp_q.pop_front();
          chk("bus_id", 32'(bus_id), 32'(e[DW+1:DW]));
          chk("bus_data", 32'(bus_data), 32'(e[DW-1:0]));
        end
      end else if (exp_q.size() != 0) begin
        chk("bus_missing", 32'(bus_valid), 32'd1);
        exp_q.delete();
      end
    end
  end

  function automatic logic [3:0] model_req();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  function automatic logic [3:0] model_full();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() == DEPTH);
    return r;
  endfunction

  // Called at posedge+1: drive inputs, let one edge pass, update model and check state.
  task automatic step(input logic [3:0] we, input logic [4*DW-1:0] wd, input logic [3:0] g);
    logic [3:0] do_push, do_pop;
    logic       onehot, wasted;
    wr_en = we; wr_data = wd; GNT = g;
    onehot = ($countones(g) == 1);
    wasted = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_pop[i]  = onehot && g[i] && mq[i].size() != 0;
      do_push[i] = we[i] && mq[i].size() < DEPTH;
      if (onehot && g[i] && mq[i].size() == 0) wasted = 1'b1;
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (do_pop[i]) exp_q.push_back({2'(i), mq[i].pop_front()});
      if (do_push[i]) mq[i].push_back(wd[i*DW +: DW]);
    end
    if ($countones(g) >= 2) m_err = 1'b1;
`ifdef RR_REQ_STATS_EN
    if (wasted && m_waste < 255) m_waste++;
`endif
    #1;
    chk("REQ", 32'(REQ), 32'(model_req()));
    chk("full", 32'(full), 32'(model_full()));
    chk("gnt_err", 32'(gnt_err), 32'(m_err));
    chk("waste_cnt", 32'(waste_cnt), 32'(m_waste));
  endtask

  function automatic logic [4*DW-1:0] wd_at(input int ch, input logic [DW-1:0] v);
    logic [4*DW-1:0] r;
    r = '0;
    r[ch*DW +: DW] = v;
    return r;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'b0000, '0, 4'b0000);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) mq[i].delete();
    exp_q.delete();
    m_err = 1'b0;
    m_waste = 0;
  endtask

  initial begin
    rst = 1'b1; wr_en = '0; wr_data = '0; GNT = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_REQ", 32'(REQ), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_id", 32'(bus_id), 32'd0);
    chk("rst_bus_data", 32'(bus_data), 32'd0);
    chk("rst_gnt_err", 32'(gnt_err), 32'd0);
    chk("rst_waste", 32'(waste_cnt), 32'd0);

    // ch0: two words, granted back to back
    step(4'b0001, wd_at(0, 8'hA1), 4'b0000);
    chk("req_after_push", 32'(REQ), 32'h1);
    step(4'b0001, wd_at(0, 8'hA2), 4'b0000);
    step(4'b0000, '0, 4'b0001);
    step(4'b0000, '0, 4'b0001);
    chk("req_drop_last_pop", 32'(REQ), 32'h0);
    idle(2);

    // ch2: fill, fifth push dropped while popping
    for (int k = 0; k < 4; k++) step(4'b0100, wd_at(2, 8'hC0 + 8'(k)), 4'b0000);
    chk("full2", 32'(full), 32'h4);
    step(4'b0100, wd_at(2, 8'hCF), 4'b0100);
    chk("full2_after_pop", 32'(full), 32'h0);
    for (int k = 0; k < 3; k++) step(4'b0000, '0, 4'b0100);
    chk("req2_empty", 32'(REQ), 32'h0);
    idle(2);

    // waste: ch3 granted while empty
    for (int k = 0; k < 3; k++) step(4'b0000, '0, 4'b1000);
`ifdef RR_REQ_STATS_EN
    chk("waste3", 32'(waste_cnt), 32'd3);
`else
    chk("waste_off", 32'(waste_cnt), 32'd0);
`endif
    idle(1);

    // two-hot grant: no pop, sticky error
    step(4'b0011, wd_at(0, 8'h10) | wd_at(1, 8'h11), 4'b0000);
    step(4'b0000, '0, 4'b0011);
    chk("gnt_err_set", 32'(gnt_err), 32'd1);
    chk("req_kept", 32'(REQ), 32'h3);
    step(4'b0000, '0, 4'b0001);
    step(4'b0000, '0, 4'b0010);
    chk("gnt_err_sticky", 32'(gnt_err), 32'd1);
    idle(2);

    // pointer wrap on ch1: simultaneous push/pop for 10 cycles
    step(4'b0010, wd_at(1, 8'h50), 4'b0000);
    for (int k = 1; k <= 10; k++) step(4'b0010, wd_at(1, 8'h50 + 8'(k)), 4'b0010);
    step(4'b0000, '0, 4'b0010);
    idle(2);

    // async reset mid-stream with all channels holding data
    step(4'b1111, {8'hD3, 8'hD2, 8'hD1, 8'hD0}, 4'b0000);
    step(4'b1111, {8'hE3, 8'hE2, 8'hE1, 8'hE0}, 4'b0001);
    #3;
    rst = 1'b1;
    wr_en = '0; GNT = '0;
    #1;
    chk("mid_rst_REQ", 32'(REQ), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("mid_rst_gnt_err", 32'(gnt_err), 32'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b0100, wd_at(2, 8'h77), 4'b0000);
    step(4'b0000, '0, 4'b0100);
    step(4'b0000, '0, 4'b0100);
    idle(2);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [3:0] we, g;
      logic [4*DW-1:0] wd;
      int r;
      we = 4'($urandom);
      wd = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      r = $urandom_range(0, 19);
      if (r < 3) g = 4'b0000;
      else if (r == 3) g = 4'($urandom);
      else g = 4'b0001 << $urandom_range(0, 3);
      step(we, wd, g);
    end
    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
